// File: rtl/sim_mem_model.sv
// sim_mem_model: byte-addressed bench memory with per-direction latency, a combinational fetch port,
// console/halt MMIO and sticky error flags. Memory contents are written only through the data port.
module sim_mem_model #(
    parameter int unsigned MEM_BYTES    = 262144,
    parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
    parameter int unsigned RD_LATENCY   = 0,
    parameter int unsigned WR_LATENCY   = 0,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h1000_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic [3:0]  mem_rmask,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    input  logic [31:0] pc,
    output logic [31:0] insn,
    output logic        console_valid,
    output logic [7:0]  console_data,
    output logic        halt,
    output logic [31:0] halt_code,
    output logic        err_oob,
    output logic        err_proto
);

    localparam int unsigned IDX_W   = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
    localparam logic [32:0] MEM_END = 33'(ADDR_BASE) + 33'(MEM_BYTES);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // Lane k of an access at a is in range only if a+k neither wraps nor leaves the window.
    function automatic logic lane_in(input logic [31:0] a, input logic [1:0] k);
        logic [32:0] s;
        s = 33'(a) + 33'(k);
        return !s[32] && (s >= 33'(ADDR_BASE)) && (s < MEM_END);
    endfunction

    function automatic logic [IDX_W-1:0] lane_idx(input logic [31:0] a, input logic [1:0] k);
        logic [31:0] off;
        off = a + 32'(k) - ADDR_BASE;
        return off[IDX_W-1:0];
    endfunction

    logic [7:0]            r_mem [MEM_BYTES];
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_is_wr;
    logic [31:0]           r_rdata;
    logic                  r_con_valid;
    logic [7:0]            r_con_data;
    logic                  r_halt;
    logic [31:0]           r_halt_code;
    logic                  r_err_oob;
    logic                  r_err_proto;
    logic [31:0]           r_n_fetch;
    logic [31:0]           r_n_data;

    logic                  w_is_wr;
    logic                  w_wr;
    logic                  w_fast_ok;
    logic                  w_fast;
    logic                  w_commit;
    logic                  w_is_con;
    logic                  w_is_hlt;
    logic                  w_is_mmio;
    logic                  w_oob;
    logic [3:0]            w_ok;
    logic [3:0]            w_en;
    logic [3:0]            w_pc_ok;
    logic [3:0][IDX_W-1:0] w_idx;
    logic [3:0][IDX_W-1:0] w_pc_idx;
    logic [31:0]           w_rdata;
    logic [31:0]           w_insn;
    logic [CNT_W-1:0]      w_cnt_load;
    logic [CNT_W-1:0]      w_cnt_dec;

    // Request decode, lane mapping and combinational read paths.
    always_comb begin
        w_is_wr    = |mem_wstrb;
        w_wr       = (r_state == S_IDLE) ? w_is_wr : r_is_wr;
        w_fast_ok  = w_is_wr ? (WR_LATENCY == 0) : (RD_LATENCY == 0);
        w_fast     = (r_state == S_IDLE) && mem_valid && w_fast_ok;
        w_commit   = !reset && mem_valid && (w_fast || (r_state == S_RESP));
        w_is_con   = (mem_addr == CONSOLE_ADDR);
        w_is_hlt   = (mem_addr == HALT_ADDR);
        w_is_mmio  = w_is_con || w_is_hlt;
        w_en       = w_wr ? mem_wstrb : mem_rmask;
        w_cnt_load = w_is_wr ? CNT_W'(WR_LATENCY - 1) : CNT_W'(RD_LATENCY - 1);
        w_cnt_dec  = r_cnt - CNT_W'(1);
        w_rdata    = '0;
        w_insn     = '0;
        for (int k = 0; k < 4; k++) begin
            w_ok[k]     = lane_in(mem_addr, 2'(k));
            w_idx[k]    = lane_idx(mem_addr, 2'(k));
            w_pc_ok[k]  = lane_in(pc, 2'(k));
            w_pc_idx[k] = lane_idx(pc, 2'(k));
            if (mem_rmask[k] && w_ok[k] && !w_is_mmio) begin
                w_rdata[8*k +: 8] = r_mem[w_idx[k]];
            end
            w_insn[8*k +: 8] = r_mem[w_pc_idx[k]];
        end
        w_oob = !w_is_mmio && (|(w_en & ~w_ok));
    end

    // Handshake FSM plus MMIO side effects and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_rdata     <= '0;
            r_con_valid <= 1'b0;
            r_con_data  <= '0;
            r_halt      <= 1'b0;
            r_halt_code <= '0;
            r_err_oob   <= 1'b0;
            r_err_proto <= 1'b0;
            r_n_fetch   <= '0;
            r_n_data    <= '0;
        end else begin
            r_con_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_valid && !w_fast_ok) begin
                        r_is_wr <= w_is_wr;
                        r_cnt   <= w_cnt_load;
                        if (w_cnt_load == '0) begin
                            r_state <= S_RESP;
                            r_rdata <= w_rdata;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!mem_valid) begin
                        r_state     <= S_IDLE;
                        r_err_proto <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_dec;
                        if (w_cnt_dec == '0) begin
                            r_state <= S_RESP;
                            r_rdata <= w_rdata;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    if (!mem_valid) begin
                        r_err_proto <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_commit) begin
                if (w_wr && w_is_con) begin
                    r_con_valid <= 1'b1;
                    r_con_data  <= mem_wdata[7:0];
                end
                if (w_wr && w_is_hlt) begin
                    r_halt <= 1'b1;
                    if (!r_halt) begin
                        r_halt_code <= mem_wdata;
                    end
                end
                if (w_oob) begin
                    r_err_oob <= 1'b1;
                end
                if (mem_instr) begin
                    r_n_fetch <= r_n_fetch + 32'd1;
                end else begin
                    r_n_data <= r_n_data + 32'd1;
                end
            end
        end
    end

    // Byte-lane write commit; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_wr && !w_is_mmio) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_wstrb[k] && w_ok[k]) begin
                    r_mem[w_idx[k]] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    assign mem_ready     = (r_state == S_RESP) || w_fast;
    assign mem_rdata     = (r_state == S_RESP) ? r_rdata : ((RD_LATENCY == 0) ? w_rdata : 32'h0);
    assign insn          = (&w_pc_ok) ? w_insn : NOP;
    assign console_valid = r_con_valid;
    assign console_data  = r_con_data;
    assign halt          = r_halt;
    assign halt_code     = r_halt_code;
    assign err_oob       = r_err_oob;
    assign err_proto     = r_err_proto;

endmodule
